// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, condition
// codes, data-processing command codes, datapath mux selects and ALU decode.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_EOR   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  typedef struct packed {
    logic [2:0] alu_ctl;
    logic [1:0] flag_w;
    logic       no_write;
  } alu_dec_t;

  // Unsupported commands decode to a harmless ADD with no register or flag write.
  function automatic alu_dec_t alu_decode(input logic [5:0] funct, input logic ext);
    alu_dec_t   d;
    logic       s;
    logic [1:0] fw_arith;
    logic [1:0] fw_logic;
    s        = funct[0];
    fw_arith = s ? 2'b11 : 2'b00;
    fw_logic = s ? 2'b10 : 2'b00;
    d.alu_ctl  = ALU_ADD;
    d.flag_w   = 2'b00;
    d.no_write = 1'b1;
    case (funct[4:1])
      CMD_ADD: begin d.alu_ctl = ALU_ADD; d.flag_w = fw_arith; d.no_write = 1'b0; end
      CMD_SUB: begin d.alu_ctl = ALU_SUB; d.flag_w = fw_arith; d.no_write = 1'b0; end
      CMD_AND: begin d.alu_ctl = ALU_AND; d.flag_w = fw_logic; d.no_write = 1'b0; end
      CMD_ORR: begin d.alu_ctl = ALU_ORR; d.flag_w = fw_logic; d.no_write = 1'b0; end
      CMD_CMP: begin d.alu_ctl = ALU_SUB; d.flag_w = 2'b11;    d.no_write = 1'b1; end
      CMD_EOR: if (ext) begin d.alu_ctl = ALU_EOR;   d.flag_w = fw_logic; d.no_write = 1'b0; end
      CMD_TST: if (ext) begin d.alu_ctl = ALU_AND;   d.flag_w = 2'b10;    d.no_write = 1'b1; end
      CMD_CMN: if (ext) begin d.alu_ctl = ALU_ADD;   d.flag_w = 2'b11;    d.no_write = 1'b1; end
      CMD_MOV: if (ext) begin d.alu_ctl = ALU_PASSB; d.flag_w = fw_logic; d.no_write = 1'b0; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Architectural NZCV flags register and the ARM condition-code check.
// CondEx is evaluated against the registered flags, so updates land for the next instruction.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       flag_en_i,
  output logic       cond_ex_o,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;
  logic       cond_ex;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_en_i && cond_ex) begin
      if (flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
      if (flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign cond_ex_o = cond_ex;
  assign flags_o   = flags_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: per-instruction sequencing FSM, ALU decode and
// write-enable generation; flags and condition check live in cond_unit.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 (waits on MemRdy when MEM_WAIT)
// DECODE | read registers, compute PC+8 for branch/PC reads
// MEMADR | compute load/store address
// MEMRD  | read data memory (waits on MemRdy)
// MEMWB  | write loaded data to register file
// MEMWR  | write data memory (waits on MemRdy)
// EXECR  | ALU op with register operand, update flags
// EXECI  | ALU op with immediate operand, update flags
// ALUWB  | write ALU result to register file
// BRANCH | write branch target to PC
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned EXT_OPS  = 0,
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       MemRdy,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemW,
  output logic       IRWrite,
  output logic       RegW,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  state_e     state_q, state_d, cur_st;
  alu_dec_t   dec;
  logic       mem_rdy;
  logic       cond_ex;
  logic       flag_en;
  logic       pc_write, ir_write, reg_w, mem_w;
  logic       adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src;
  logic [2:0] alu_ctl;

  assign mem_rdy = (MEM_WAIT != 0) ? MemRdy : 1'b1;
  assign dec     = alu_decode(Funct, EXT_OPS != 0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // During reset the datapath sees FETCH selects; write enables are masked below.
  assign cur_st = reset ? S_FETCH : state_q;

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_b  = SRCB_RD2;
    imm_src    = IMM_DP;
    reg_src    = 2'b00;
    alu_ctl    = ALU_ADD;
    case (cur_st)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_rdy;
        pc_write   = mem_rdy;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        reg_src[0] = (Op == 2'b10);
        reg_src[1] = (Op == 2'b01);
      end
      S_EXECR: begin
        alu_src_b = SRCB_RD2;
        alu_ctl   = dec.alu_ctl;
      end
      S_EXECI: begin
        alu_src_b = SRCB_IMM;
        alu_ctl   = dec.alu_ctl;
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_MEM;
      end
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = cond_ex;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = cond_ex;
        pc_write   = cond_ex & (Rd == 4'hF);
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_w      = cond_ex & ~dec.no_write;
        pc_write   = cond_ex & ~dec.no_write & (Rd == 4'hF);
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_BR;
        result_src = RES_ALURESULT;
        pc_write   = cond_ex;
      end
      default: ;
    endcase
  end

  assign flag_en = ~reset & ((state_q == S_EXECR) || (state_q == S_EXECI));

  cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (Cond),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (dec.flag_w),
    .flag_en_i   (flag_en),
    .cond_ex_o   (cond_ex),
    .flags_o     (Flags)
  );

  assign PCWrite    = pc_write & ~reset;
  assign IRWrite    = ir_write & ~reset;
  assign RegW       = reg_w & ~reset;
  assign MemW       = mem_w & ~reset;
  assign AdrSrc     = adr_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ResultSrc  = result_src;
  assign ImmSrc     = imm_src;
  assign RegSrc     = reg_src;
  assign ALUControl = alu_ctl;
  assign State      = cur_st;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-cycle expectations are queued by the stimulus and a
// negedge monitor pops and compares them against two controller configurations.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s [2];
  logic [3:0] cond_s  [2];
  logic [1:0] op_s    [2];
  logic [5:0] funct_s [2];
  logic [3:0] rd_s    [2];
  logic [3:0] aluf_s  [2];
  logic       rdy_s   [2];

  logic       pcw  [2];
  logic       adr  [2];
  logic       memw [2];
  logic       irw  [2];
  logic       regw [2];
  logic [1:0] res  [2];
  logic       srca [2];
  logic [1:0] srcb [2];
  logic [1:0] imm  [2];
  logic [1:0] rsrc [2];
  logic [2:0] alu  [2];
  logic [3:0] flg  [2];
  logic [3:0] st   [2];

  multicycle_controller #(.EXT_OPS(0), .MEM_WAIT(0)) u0 (
    .clk(clk), .reset(reset_s[0]), .Cond(cond_s[0]), .Op(op_s[0]), .Funct(funct_s[0]),
    .Rd(rd_s[0]), .ALUFlags(aluf_s[0]), .MemRdy(rdy_s[0]),
    .PCWrite(pcw[0]), .AdrSrc(adr[0]), .MemW(memw[0]), .IRWrite(irw[0]), .RegW(regw[0]),
    .ResultSrc(res[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]), .ImmSrc(imm[0]),
    .RegSrc(rsrc[0]), .ALUControl(alu[0]), .Flags(flg[0]), .State(st[0])
  );

  multicycle_controller #(.EXT_OPS(1), .MEM_WAIT(1)) u1 (
    .clk(clk), .reset(reset_s[1]), .Cond(cond_s[1]), .Op(op_s[1]), .Funct(funct_s[1]),
    .Rd(rd_s[1]), .ALUFlags(aluf_s[1]), .MemRdy(rdy_s[1]),
    .PCWrite(pcw[1]), .AdrSrc(adr[1]), .MemW(memw[1]), .IRWrite(irw[1]), .RegW(regw[1]),
    .ResultSrc(res[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]), .ImmSrc(imm[1]),
    .RegSrc(rsrc[1]), .ALUControl(alu[1]), .Flags(flg[1]), .State(st[1])
  );

  typedef struct {
    string      name;
    logic       chk_st;
    logic [3:0] st;
    logic [16:0] ctl;
    logic       chk_fl;
    logic [3:0] fl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [3:0] ef [2];
  int n_tests = 0;
  int n_fail  = 0;

  // {PCWrite,AdrSrc,MemW,IRWrite,RegW,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegSrc,ALUControl}
  function automatic logic [16:0] ctl(input logic p, input logic a, input logic m, input logic i,
                                      input logic r, input logic [1:0] rs, input logic sa,
                                      input logic [1:0] sb, input logic [1:0] im,
                                      input logic [1:0] rg, input logic [2:0] al);
    return {p, a, m, i, r, rs, sa, sb, im, rg, al};
  endfunction

  task automatic push(input int d, input string nm, input logic cs, input logic [3:0] s,
                      input logic [16:0] c, input logic cf);
    exp_t e;
    e.name = nm; e.chk_st = cs; e.st = s; e.ctl = c; e.chk_fl = cf; e.fl = ef[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic e_reset(input int d, input logic chk);
    push(d, "reset", chk, 4'd0, ctl(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b00,3'b000), chk);
  endtask
  task automatic e_fetch(input int d, input logic rdy);
    push(d, "fetch", 1'b1, 4'd0, ctl(rdy,1'b0,1'b0,rdy,1'b0,2'b10,1'b1,2'b10,2'b00,2'b00,3'b000), 1'b1);
  endtask
  task automatic e_decode(input int d, input logic [1:0] rg);
    push(d, "decode", 1'b1, 4'd1, ctl(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,rg,3'b000), 1'b1);
  endtask
  task automatic e_memadr(input int d);
    push(d, "memadr", 1'b1, 4'd2, ctl(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b01,2'b00,3'b000), 1'b1);
  endtask
  task automatic e_memrd(input int d);
    push(d, "memrd", 1'b1, 4'd3, ctl(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,3'b000), 1'b1);
  endtask
  task automatic e_memwb(input int d, input logic rw, input logic p);
    push(d, "memwb", 1'b1, 4'd4, ctl(p,1'b0,1'b0,1'b0,rw,2'b01,1'b0,2'b00,2'b00,2'b00,3'b000), 1'b1);
  endtask
  task automatic e_memwr(input int d);
    push(d, "memwr", 1'b1, 4'd5, ctl(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,3'b000), 1'b1);
  endtask
  task automatic e_execr(input int d, input logic [2:0] al);
    push(d, "execr", 1'b1, 4'd6, ctl(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,al), 1'b1);
  endtask
  task automatic e_execi(input int d, input logic [2:0] al);
    push(d, "execi", 1'b1, 4'd7, ctl(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,2'b00,al), 1'b1);
  endtask
  task automatic e_aluwb(input int d, input logic rw, input logic p);
    push(d, "aluwb", 1'b1, 4'd8, ctl(p,1'b0,1'b0,1'b0,rw,2'b00,1'b0,2'b00,2'b00,2'b00,3'b000), 1'b1);
  endtask
  task automatic e_branch(input int d, input logic p);
    push(d, "branch", 1'b1, 4'd9, ctl(p,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,2'b01,2'b10,2'b00,3'b000), 1'b1);
  endtask

  task automatic set_instr(input int d, input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r);
    cond_s[d] = c; op_s[d] = o; funct_s[d] = f; rd_s[d] = r;
  endtask

  task automatic check(input int d, input exp_t e);
    logic [16:0] act;
    act = {pcw[d], adr[d], memw[d], irw[d], regw[d], res[d], srca[d], srcb[d], imm[d], rsrc[d], alu[d]};
    n_tests++;
    if (act !== e.ctl || (e.chk_st && st[d] !== e.st) || (e.chk_fl && flg[d] !== e.fl)) begin
      n_fail++;
      $display("FAIL u%0d %s @%0t: got ctl=%b state=%0d flags=%b, want ctl=%b state=%0d flags=%b",
               d, e.name, $time, act, st[d], flg[d], e.ctl, e.st, e.fl);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check(0, q0.pop_front());
    if (q1.size() > 0) check(1, q1.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b1; aluf_s[d] = 4'b0000; rdy_s[d] = 1'b0; ef[d] = 4'b0000;
      set_instr(d, 4'hE, 2'b00, 6'b000000, 4'd0);
    end
    tick();
    e_reset(0, 1'b1); e_reset(1, 1'b1); tick();

    // ---- u0: EXT_OPS=0, MEM_WAIT=0 (MemRdy held low, must be ignored) ----
    reset_s[0] = 1'b0;
    set_instr(0, 4'hE, 2'b00, 6'b001000, 4'd1);           // ADD R1,R2,R3
    e_fetch(0, 1'b1); tick(); e_decode(0, 2'b00); tick();
    e_execr(0, 3'b000); tick(); e_aluwb(0, 1'b1, 1'b0); tick();

    set_instr(0, 4'hE, 2'b00, 6'b000101, 4'd1); aluf_s[0] = 4'b0100;   // SUBS -> Z
    e_fetch(0, 1'b1); tick(); e_decode(0, 2'b00); tick();
    e_execr(0, 3'b001); tick(); ef[0] = 4'b0100; e_aluwb(0, 1'b1, 1'b0); tick();

    set_instr(0, 4'h0, 2'b00, 6'b001000, 4'd1); aluf_s[0] = 4'b0000;   // ADDEQ taken
    e_fetch(0, 1'b1); tick(); e_decode(0, 2'b00); tick();
    e_execr(0, 3'b000); tick(); e_aluwb(0, 1'b1, 1'b0); tick();

    set_instr(0, 4'hE, 2'b00, 6'b000101, 4'd1); aluf_s[0] = 4'b0000;   // SUBS -> clear
    e_fetch(0, 1'b1); tick(); e_decode(0, 2'b00); tick();
    e_execr(0, 3'b001); tick(); ef[0] = 4'b0000; e_aluwb(0, 1'b1, 1'b0); tick();

    set_instr(0, 4'h0, 2'b00, 6'b001000, 4'd1);           // ADDEQ not taken
    e_fetch(0, 1'b1); tick(); e_decode(0, 2'b00); tick();
    e_execr(0, 3'b000); tick(); e_aluwb(0, 1'b0, 1'b0); tick();

    set_instr(0, 4'h0, 2'b10, 6'b100000, 4'd0);           // BEQ not taken
    e_fetch(0, 1'b1); tick(); e_decode(0, 2'b01); tick(); e_branch(0, 1'b0); tick();

    set_instr(0, 4'hE, 2'b10, 6'b100000, 4'd0);           // B
    e_fetch(0, 1'b1); tick(); e_decode(0, 2'b01); tick(); e_branch(0, 1'b1); tick();

    set_instr(0, 4'hE, 2'b00, 6'b000010, 4'd1);           // EOR unsupported
    e_fetch(0, 1'b1); tick(); e_decode(0, 2'b00); tick();
    e_execr(0, 3'b000); tick(); e_aluwb(0, 1'b0, 1'b0); tick();

    set_instr(0, 4'hE, 2'b11, 6'b000000, 4'd0);           // Op=11 no-op
    e_fetch(0, 1'b1); tick(); e_decode(0, 2'b00); tick();

    set_instr(0, 4'hE, 2'b01, 6'b011001, 4'hF);           // LDR PC
    e_fetch(0, 1'b1); tick(); e_decode(0, 2'b10); tick();
    e_memadr(0); tick(); e_memrd(0); tick(); e_memwb(0, 1'b1, 1'b1); tick();
    e_fetch(0, 1'b1); tick();
    reset_s[0] = 1'b1;

    // ---- u1: EXT_OPS=1, MEM_WAIT=1 ----
    reset_s[1] = 1'b0; rdy_s[1] = 1'b0;
    set_instr(1, 4'hE, 2'b01, 6'b011000, 4'd2);           // STR with wait states
    e_fetch(1, 1'b0); tick(); e_fetch(1, 1'b0); tick();
    rdy_s[1] = 1'b1; e_fetch(1, 1'b1); tick();
    e_decode(1, 2'b10); tick(); e_memadr(1); tick();
    rdy_s[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin e_memwr(1); tick(); end
    rdy_s[1] = 1'b1; e_memwr(1); tick();

    set_instr(1, 4'hE, 2'b00, 6'b000010, 4'd1);           // EOR supported
    e_fetch(1, 1'b1); tick(); e_decode(1, 2'b00); tick();
    e_execr(1, 3'b100); tick(); e_aluwb(1, 1'b1, 1'b0); tick();

    set_instr(1, 4'hE, 2'b00, 6'b110101, 4'd0); aluf_s[1] = 4'b0110;   // CMP imm
    e_fetch(1, 1'b1); tick(); e_decode(1, 2'b00); tick();
    e_execi(1, 3'b001); tick(); ef[1] = 4'b0110; e_aluwb(1, 1'b0, 1'b0); tick();

    set_instr(1, 4'hE, 2'b01, 6'b011000, 4'd2);           // STR aborted by reset
    e_fetch(1, 1'b1); tick(); e_decode(1, 2'b10); tick(); e_memadr(1); tick();
    rdy_s[1] = 1'b0; e_memwr(1); tick();
    reset_s[1] = 1'b1; e_reset(1, 1'b0); tick();
    reset_s[1] = 1'b0; rdy_s[1] = 1'b1; ef[1] = 4'b0000;
    e_fetch(1, 1'b1); tick(); e_decode(1, 2'b10); tick();

    tick();
    n_tests++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q0.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM datapath; the next generation of the single-cycle decoder.
- Sequences each instruction through an FSM (fetch, decode, execute, memory, writeback) instead of decoding in one cycle.
- Owns the architectural NZCV flags register and the condition-check logic.
- Adds optional memory wait-states and an extended ALU command set, both selected by parameter.

Parameters:
- EXT_OPS, 0: when 1, also decode EOR, TST, CMN and MOV; when 0 those commands are unsupported.
- MEM_WAIT, 0: when 1, FETCH, MEMRD and MEMWR hold until MemRdy=1; when 0, MemRdy is ignored (treated as 1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  NZCV from the ALU, current cycle
- MemRdy  in  1  memory access complete
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemW  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- RegW  out  1  register file write enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  ALU A select: 0=RD1, 1=PC
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  immediate format: 00=DP, 01=Mem, 10=Branch
- RegSrc  out  2  register read-address selects
- ALUControl  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 PASS-B
- Flags  out  4  registered NZCV, for debug
- State  out  4  current FSM state, for debug

Behaviour:
- Reset, while reset=1:
  - Next state is FETCH; Flags <= 0000.
  - PCWrite, IRWrite, RegW and MemW are forced to 0.
  - All other outputs take their FETCH values.
- State encoding and transitions:
  - 0 FETCH -> DECODE, when MemRdy=1 or MEM_WAIT=0.
  - 1 DECODE branches on Op:
    - Op=01 -> MEMADR.
    - Op=10 -> BRANCH.
    - Op=00 with Funct[5]=0 -> EXECR.
    - Op=00 with Funct[5]=1 -> EXECI.
    - Op=11 -> FETCH; treated as a no-op.
  - 2 MEMADR -> MEMRD when Funct[0]=1, else MEMWR.
  - 3 MEMRD -> MEMWB, after the MemRdy wait.
  - 4 MEMWB -> FETCH.
  - 5 MEMWR -> FETCH, after the MemRdy wait.
  - 6 EXECR and 7 EXECI -> ALUWB.
  - 8 ALUWB -> FETCH.
  - 9 BRANCH -> FETCH.
- Per-state outputs (anything not listed is 0 / 00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1. IRWrite and PCWrite are asserted only on the cycle the transition to DECODE is taken.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. RegSrc[0]=1 when Op=10; RegSrc[1]=1 when Op=01.
  - EXECR: ALUSrcB=00. EXECI: ALUSrcB=01.
  - MEMADR: ALUSrcB=01, ImmSrc=01.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1, MemW=CondEx. MemW is held for every wait cycle.
  - MEMWB: ResultSrc=01, RegW=CondEx.
  - ALUWB: ResultSrc=00, RegW=CondEx & ~NoWrite.
  - BRANCH: ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=CondEx.
- PC writeback: in MEMWB or ALUWB with Rd=1111 and RegW asserted, PCWrite=1 as well.
- ALU decode:
  - Active only in EXECR and EXECI; otherwise ALUControl=ADD.
  - Commands are selected by Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP.
  - With EXT_OPS=1, also: 0001 EOR, 1000 TST, 1011 CMN, 1101 MOV (PASS-B).
  - FlagW when S=1: arithmetic ops -> 11; logical ops and MOV -> 10.
  - CMP and CMN: FlagW=11, NoWrite=1, regardless of S. TST: FlagW=10, NoWrite=1.
  - Unsupported command: ALUControl=ADD, NoWrite=1, FlagW=00; the instruction has no architectural effect.
- Flags register:
  - Written only in EXECR or EXECI, at the clock edge, and only when CondEx=1.
  - FlagW[1] updates NZ from ALUFlags[3:2]; FlagW[0] updates CV from ALUFlags[1:0].
- Condition check:
  - CondEx is combinational from Cond and the registered Flags, using the standard ARM table 0000 EQ through 1110 AL.
  - Cond=1111 gives CondEx=0.
  - Flags written in instruction N are visible to instruction N+1.
- Reset mid-instruction: the instruction is aborted. No write enable is asserted in the reset cycle, and the next cycle is FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings;
  - Cond codes;
  - Funct[4:1] command codes;
  - ALUControl, ResultSrc, ALUSrcB and ImmSrc encodings.
- One sub-module, cond_unit, holds the flags register, FlagW gating and the CondEx table.

Test Plan:
- ADD R1,R2,R3, MEM_WAIT=0: states FETCH, DECODE, EXECR, ALUWB, then FETCH. RegW=1 only in ALUWB; ALUControl=000 in EXECR.
- SUBS with ALUFlags=0100, then ADDEQ: Flags=0100 after EXECR and the ADDEQ writes; repeat with ALUFlags=0000 and ADDEQ must give RegW=0.
- STR with MEM_WAIT=1, MemRdy low for 3 cycles in MEMWR: MemW=1 for 4 cycles, then FETCH. FETCH stalls with IRWrite=0 until MemRdy=1.
- LDR with Rd=1111: MEMWB gives RegW=1, PCWrite=1, ResultSrc=01.
- EXT_OPS=0, Funct[4:1]=0001: ALUControl=000 and no RegW in ALUWB. With EXT_OPS=1: ALUControl=100 and RegW=1.
- Reset asserted during MEMWR: MemW=0 that cycle; State=0 and Flags=0000 on the next cycle.
